// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the default reset PC.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_STOP = 2'd3
    } fetch_state_t;

    localparam int          INST_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch unit, with a misalignment
// flag for the selected target.
module inst_fetch_unit_next_pc_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic            bcond,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] reg_rel;
    logic [XLEN-1:0] seq_pc;

    assign pc_rel  = pc + imm;
    assign reg_rel = (rs1_data + imm) & ~XLEN'(1);
    assign seq_pc  = pc + XLEN'(4);

    // is_jalr outranks is_jal when both are set
    always_comb begin
        next_pc = seq_pc;
        if (is_jalr) begin
            next_pc = reg_rel;
        end else if (is_jal) begin
            next_pc = pc_rel;
        end else if (branch && bcond) begin
            next_pc = pc_rel;
        end
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over
// a valid/ready request + valid response port and holds it for decode.
//
// state  | meaning
// S_REQ  | request outstanding at pc, waiting for imem_req_ready
// S_WAIT | request accepted, waiting for imem_resp_valid
// S_HOLD | instruction held for decode until inst_ready
// S_STOP | halted or faulted; only reset leaves
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    input  logic              inst_ready,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic              branch,
    input  logic              bcond,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic              halt,
    output logic              halted,
    output logic              fetch_fault
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    logic capture;
    logic advance;
    logic set_halt;
    logic set_fault;

    inst_fetch_unit_next_pc_calc #(
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .pc         (pc),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .branch     (branch),
        .bcond      (bcond),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        set_halt  = 1'b0;
        set_fault = 1'b0;
        unique case (state)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    if (halt) begin
                        set_halt  = 1'b1;
                        state_nxt = S_STOP;
                    end else if (misaligned) begin
                        set_fault = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_STOP: begin
                state_nxt = S_STOP;
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inst        <= '0;
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            if (capture) begin
                inst <= imem_resp_data;
            end
            if (advance) begin
                pc <= next_pc;
            end
            if (set_halt) begin
                halted <= 1'b1;
            end
            if (set_fault) begin
                fetch_fault <= 1'b1;
            end
        end
    end

    // Request is suppressed during the reset cycle even if state is still S_REQ
    assign imem_req_valid = (state == S_REQ) && !reset;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);
    assign pc_plus4       = pc + XLEN'(4);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: the bench plays instruction memory and
// the datapath, with hand-computed expected addresses and outputs.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_ready;
    logic        is_jal;
    logic        is_jalr;
    logic        branch;
    logic        bcond;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        halt;
    logic        halted;
    logic        fetch_fault;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .inst_ready      (inst_ready),
        .is_jal          (is_jal),
        .is_jalr         (is_jalr),
        .branch          (branch),
        .bcond           (bcond),
        .imm             (imm),
        .rs1_data        (rs1_data),
        .halt            (halt),
        .halted          (halted),
        .fetch_fault     (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All stimulus changes and sampling happen at the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_flags", {30'd0, halted, fetch_fault}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rst_req_addr", imem_req_addr, 32'h0);
    endtask

    // From S_REQ: stall req_stall cycles (with a stray response), then hand off.
    task automatic issue(input string tag, input logic [31:0] addr, input int req_stall);
        for (int i = 0; i < req_stall; i++) begin
            imem_req_ready  = 1'b0;
            imem_resp_valid = (i == 0);
            imem_resp_data  = 32'hDEAD_BEEF;
            check({tag, "_stall_valid"}, {31'd0, imem_req_valid}, 32'd1);
            check({tag, "_stall_addr"}, imem_req_addr, addr);
            step();
        end
        imem_resp_valid = 1'b0;
        check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd1);
        check({tag, "_req_addr"}, imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check({tag, "_wait_no_req"}, {31'd0, imem_req_valid}, 32'd0);
    endtask

    // From S_WAIT: delay resp_stall cycles, deliver data, check the held word.
    task automatic respond(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input int resp_stall);
        for (int i = 0; i < resp_stall; i++) begin
            check({tag, "_wait_iv"}, {31'd0, inst_valid}, 32'd0);
            step();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, "_inst"}, inst, data);
        check({tag, "_pc"}, pc, addr);
        check({tag, "_pc_plus4"}, pc_plus4, addr + 32'd4);
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        issue(tag, addr, 0);
        respond(tag, addr, data, 0);
    endtask

    task automatic accept(input logic jal, input logic jalr, input logic br, input logic bc,
                          input logic [31:0] im, input logic [31:0] rs1, input logic hl);
        is_jal     = jal;
        is_jalr    = jalr;
        branch     = br;
        bcond      = bc;
        imm        = im;
        rs1_data   = rs1;
        halt       = hl;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        branch     = 1'b0;
        bcond      = 1'b0;
        imm        = 32'h0;
        rs1_data   = 32'h0;
        halt       = 1'b0;
        check("accept_iv_drop", {31'd0, inst_valid}, 32'd0);
    endtask

    task automatic check_stopped(input string tag, input logic [31:0] exp_pc, input int cycles);
        int n_req = 0;
        int n_iv  = 0;
        for (int i = 0; i < cycles; i++) begin
            inst_ready = 1'b1;
            imem_resp_valid = 1'b1;
            if (imem_req_valid) n_req++;
            if (inst_valid) n_iv++;
            step();
        end
        inst_ready      = 1'b0;
        imem_resp_valid = 1'b0;
        check({tag, "_no_req"}, n_req, 32'd0);
        check({tag, "_no_iv"}, n_iv, 32'd0);
        check({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        is_jal          = 1'b0;
        is_jalr         = 1'b0;
        branch          = 1'b0;
        bcond           = 1'b0;
        imm             = 32'h0;
        rs1_data        = 32'h0;
        halt            = 1'b0;
        step();
        do_reset();

        // zero-wait fetch, sequential advance
        fetch("first", 32'h0, 32'h0050_0093);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // backpressure on both request and response
        issue("bp", 32'h4, 3);
        respond("bp", 32'h4, 32'h1234_5678, 4);
        step();
        check("bp_hold_inst", inst, 32'h1234_5678);
        check("bp_hold_req", {31'd0, imem_req_valid}, 32'd0);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0, 1'b0);

        // branch taken / not taken at 0x10
        fetch("br_t", 32'h10, 32'h0000_0063);
        accept(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0);
        fetch("br_tgt", 32'h08, 32'h0000_0013);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        fetch("br_nt", 32'h10, 32'h0000_0063);
        accept(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0);
        fetch("br_seq", 32'h14, 32'h0000_0013);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0, 1'b0);

        // JALR with is_jal also set: JALR wins, bit0 cleared
        fetch("jalr", 32'h20, 32'h0040_8067);
        accept(1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h101, 1'b0);
        fetch("jalr_tgt", 32'h104, 32'h0000_0013);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF1C, 32'h0, 1'b0);

        // misaligned JAL target 0x26 faults
        fetch("jal_mis", 32'h20, 32'h0060_006F);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h6, 32'h0, 1'b0);
        check("fault_set", {30'd0, halted, fetch_fault}, 32'd1);
        check_stopped("fault", 32'h20, 5);

        // halt at 0x40 beats a simultaneous redirect
        do_reset();
        fetch("h0", 32'h0, 32'h0000_0013);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        fetch("halt", 32'h40, 32'h0000_0073);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1);
        check("halt_set", {30'd0, halted, fetch_fault}, 32'd2);
        check_stopped("halt", 32'h40, 20);
        do_reset();

        // PC wrap from 0xFFFF_FFFC is not a fault
        fetch("w0", 32'h0, 32'h0000_0013);
        accept(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0013);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wrap_no_fault", {30'd0, halted, fetch_fault}, 32'd0);
        fetch("wrapped", 32'h0, 32'h0000_0013);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);

        // reset in S_WAIT coinciding with a response
        issue("rw", 32'h40, 0);
        reset           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_F00D;
        step();
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        #1;
        check("rw_pc", pc, 32'h0);
        check("rw_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rw_inst", inst, 32'h0);
        check("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rw_req_addr", imem_req_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Owns the program counter and fetches one instruction at a time from instruction memory over a valid/ready request plus valid response interface.
- Presents the held instruction to decode. Decode feeds inst[6:0] to the control unit.
- Computes the next PC when the downstream datapath accepts the instruction. The datapath returns the control and branch outcome with the accept.
- Sits directly upstream of the decode/control stage.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address; always equals pc.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  inst/pc hold a valid instruction.
- inst  out  32  held instruction.
- pc  out  XLEN  PC of the held instruction.
- pc_plus4  out  XLEN  pc+4, used as the link value for JAL/JALR.
- inst_ready  in  1  datapath completes the held instruction this cycle.
- is_jal  in  1  control of the completing instruction.
- is_jalr  in  1  control of the completing instruction.
- branch  in  1  control of the completing instruction.
- bcond  in  1  ALU branch-taken result.
- imm  in  XLEN  immediate of the completing instruction.
- rs1_data  in  XLEN  rs1 value, used for the JALR target.
- halt  in  1  the completing instruction is ECALL-halt.
- halted  out  1  sticky; fetch stopped by halt.
- fetch_fault  out  1  sticky; misaligned next PC detected.

Behaviour:
- Reset (synchronous, active-high) has priority over every other event. It applies in any state, including mid-request or while holding.
- Reset values: state=S_REQ, pc=RESET_PC, inst=0, inst_valid=0, imem_req_valid=0 during the reset cycle, halted=0, fetch_fault=0.
- The instruction memory shares this reset. Responses to requests issued before reset are never delivered.
- State machine, 2-bit encoding:
  - S_REQ: imem_req_valid=1, addr=pc. If imem_req_ready=1, go to S_WAIT; otherwise stay with addr held stable.
  - S_WAIT: imem_req_valid=0. If imem_resp_valid=1, capture inst<=imem_resp_data and go to S_HOLD. Otherwise wait indefinitely.
  - S_HOLD: inst_valid=1, with inst and pc stable. On inst_ready=1, take the first matching branch:
    - If halt: go to S_STOP, set halted=1, leave pc unchanged.
    - Else if next_pc[1:0]!=0: go to S_STOP, set fetch_fault=1, leave pc unchanged.
    - Else: pc<=next_pc and go to S_REQ.
  - S_STOP: terminal. No requests, inst_valid=0. Exit only by reset.
- imem_resp_valid outside S_WAIT is ignored.
- inst_ready outside S_HOLD is ignored. Redirect inputs are sampled only when S_HOLD and inst_ready are both true.
- next_pc priority (XLEN-bit wrap-around addition, carry discarded):
  - is_jalr: (rs1_data+imm) & ~1.
  - else is_jal: pc+imm.
  - else branch & bcond: pc+imm.
  - else: pc+4.
- If is_jal and is_jalr are both asserted, is_jalr wins.
- If halt and a redirect are both asserted, halt wins.
- inst_valid drops in the cycle after acceptance.
- Latency:
  - First request is issued in the cycle after reset deasserts.
  - With zero-wait memory (ready=1, response one cycle later), the throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- pc=32'hFFFF_FFFC with a sequential next PC wraps to 0. This is not a fault.

Decomposition:
- fetch_defs.v holds:
  - S_REQ/S_WAIT/S_HOLD/S_STOP state localparams.
  - Default RESET_PC.
- Reuses the existing opcodes.v. No new opcode constants.
- One natural combinational sub-module: next_pc_calc, which takes pc, imm, rs1_data, is_jal, is_jalr, branch and bcond, and produces next_pc and misaligned.

Test Plan:
- Reset, then zero-wait memory returning 32'h00500093 at address 0. Response: imem_req_addr=0 in the cycle after reset; inst_valid=1 two cycles later with inst=32'h00500093 and pc=0. After inst_ready with no redirect, the next request addr=4.
- Backpressure: hold imem_req_ready=0 for 3 cycles, then return the response after 4 wait cycles. Response: addr stays stable and imem_req_valid stays 1 throughout; exactly one instruction is captured; a stray imem_resp_valid during S_REQ is ignored.
- Taken branch at pc=0x10: branch=1, bcond=1, imm=-8. Response: next request addr=0x08. Repeat with bcond=0. Response: addr=0x14.
- JALR at pc=0x20: rs1_data=0x101, imm=4. Response: addr=0x104 with bit0 cleared, and pc_plus4=0x24 while holding. JAL with imm=0x6, giving target 0x26. Response: fetch_fault=1, no further requests, pc stays 0x20.
- Halt on accept at pc=0x40. Response: halted=1, inst_valid=0, imem_req_valid stays 0 for 20 cycles. Then pulse reset. Response: halted=0 and a request at RESET_PC.
- Reset asserted in S_WAIT while a response arrives in the same cycle. Response: the response is discarded, pc=RESET_PC, inst_valid=0, and the next cycle is in S_REQ.
